// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder slice.
//   NIBBLE_W : width of one adder stage
//   state_t  : controller state encoding
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
//   start      : request, honoured only while the adder is idle
//   A, B, Cin  : operands and initial carry, captured on accepted start
//   sum, Cout  : registered result of the last completed add
//   busy       : add in progress
//   done       : one-cycle pulse, sum/Cout just updated
// master = operand source / result consumer, slave = the adder.
interface nibble_serial_adder_if
   import nibble_serial_adder_pkg::*;
   #(parameter int NIBBLES = 4);

   localparam int W = NIBBLE_W * NIBBLES;

   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic [W-1:0] sum;
   logic         Cout;
   logic         busy;
   logic         done;

   modport master (
      output start, A, B, Cin,
      input  sum, Cout, busy, done
   );

   modport slave (
      input  start, A, B, Cin,
      output sum, Cout, busy, done
   );

endinterface : nibble_serial_adder_if

// File: rtl/nibble_serial_adder_ripple_adder.sv
// 4-bit ripple-carry adder stage (purely combinational).
//   A, B : nibble operands
//   Cin  : carry in
//   sum  : nibble sum
//   Cout : carry out of the top bit
module ripple_adder
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] A,
   input  logic [NIBBLE_W-1:0] B,
   input  logic                Cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                Cout
);

   logic [NIBBLE_W:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = Cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         sum[i]   = A[i] ^ B[i] ^ c[i];
         c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
      end
      Cout = c[NIBBLE_W];
   end

endmodule : ripple_adder

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple_adder stage over NIBBLES clocks,
// LSB nibble first, with the stage carry registered between nibbles.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of nibble_serial_adder_if (start/A/B/Cin in,
//         sum/Cout/busy/done out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sum/Cout hold the last completed result
// RUN   | adding one nibble per clock; start ignored
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
   #(parameter int NIBBLES = 4)
(
   input  logic                  clk,
   input  logic                  rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t           state_q, state_d;
   logic [W-1:0]     opa_q, opa_d;
   logic [W-1:0]     opb_q, opb_d;
   logic [W-1:0]     partial_q, partial_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;

   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_cout;

   ripple_adder u_stage (
      .A    (opa_q[NIBBLE_W-1:0]),
      .B    (opb_q[NIBBLE_W-1:0]),
      .Cin  (carry_q),
      .sum  (nib_sum),
      .Cout (nib_cout)
   );

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      partial_d = partial_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               opa_d     = bus.A;
               opb_d     = bus.B;
               carry_d   = bus.Cin;
               idx_d     = '0;
               partial_d = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            partial_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
            carry_d = nib_cout;
            opa_d   = opa_q >> NIBBLE_W;
            opb_d   = opb_q >> NIBBLE_W;
            idx_d   = idx_q + IDX_W'(1);
            // Publish including the nibble being written this edge.
            if (idx_q == LAST_IDX) begin
               sum_d   = partial_d;
               cout_d  = nib_cout;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         partial_q <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         partial_q <= partial_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         done_q    <= done_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.Cout = cout_q;
   assign bus.busy = (state_q == RUN);
   assign bus.done = done_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   localparam int NIB = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

   nibble_serial_adder #(.NIBBLES(NIB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] exp_sum;
      logic        exp_cout;
   } vec_t;

   vec_t vecs [7];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; samples afterwards are 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.Cin   = cin;
      step();
      bus.start = 1'b0;
   endtask

   // Waits for done; checks busy stays high and sum holds prev_sum meanwhile.
   task automatic wait_done(input logic [15:0] prev_sum, output int lat);
      bit seen = 0;
      bit busy_ok = 1;
      bit hold_ok = 1;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.busy !== 1'b1) busy_ok = 0;
         if (bus.sum !== prev_sum) hold_ok = 0;
         step();
         lat++;
         if (bus.done === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("busy_during_run", 32'(busy_ok), 32'd1);
      chk("sum_hold_during_run", 32'(hold_ok), 32'd1);
      chk("busy_at_done", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int lat;
      int dones;
      logic [15:0] prev;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[6] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};

      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Cin   = 1'b0;
      rst       = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_sum", 32'(bus.sum), 32'h0);
      chk("reset_cout", 32'(bus.Cout), 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_done", 32'(bus.done), 32'h0);
      step();

      prev = 16'h0000;
      for (int i = 0; i < 7; i++) begin
         start_add(vecs[i].a, vecs[i].b, vecs[i].cin);
         wait_done(prev, lat);
         chk("latency", 32'(lat), 32'(NIB));
         chk("sum", 32'(bus.sum), 32'(vecs[i].exp_sum));
         chk("cout", 32'(bus.Cout), 32'(vecs[i].exp_cout));
         step();
         chk("done_one_cycle", 32'(bus.done), 32'h0);
         chk("sum_hold_idle", 32'(bus.sum), 32'(vecs[i].exp_sum));
         prev = vecs[i].exp_sum;
      end

      // Start while busy is ignored; operand changes during RUN are harmless.
      start_add(16'h1234, 16'h1111, 1'b0);
      dones = 0;
      step();
      bus.start = 1'b1;
      bus.A     = 16'hFFFF;
      bus.B     = 16'hFFFF;
      bus.Cin   = 1'b1;
      step();
      bus.start = 1'b0;
      bus.A     = 16'hAAAA;
      bus.B     = 16'h5555;
      for (int i = 0; i < 12; i++) begin
         if (bus.done === 1'b1) begin
            dones++;
            chk("ignored_start_sum", 32'(bus.sum), 32'h2345);
            chk("ignored_start_cout", 32'(bus.Cout), 32'h0);
         end
         step();
      end
      chk("ignored_start_done_count", 32'(dones), 32'd1);
      chk("ignored_start_idle", 32'(bus.busy), 32'h0);

      // Back-to-back: start accepted in the done cycle.
      start_add(16'h0001, 16'h0002, 1'b0);
      wait_done(16'h2345, lat);
      chk("b2b_first_sum", 32'(bus.sum), 32'h0003);
      start_add(16'h0F0F, 16'h00F1, 1'b0);
      chk("b2b_busy", 32'(bus.busy), 32'h1);
      wait_done(16'h0003, lat);
      chk("b2b_latency", 32'(lat), 32'(NIB));
      chk("b2b_sum", 32'(bus.sum), 32'h1000);
      chk("b2b_cout", 32'(bus.Cout), 32'h0);
      step();

      // Reset in the middle of RUN aborts without done.
      start_add(16'h0001, 16'h0001, 1'b0);
      wait_done(16'h1000, lat);
      chk("pre_abort_sum", 32'(bus.sum), 32'h0002);
      step();
      start_add(16'h8000, 16'h8000, 1'b0);
      step();
      rst = 1'b1;
      chk("abort_no_done_before", 32'(bus.done), 32'h0);
      step();
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'h0);
      chk("abort_sum", 32'(bus.sum), 32'h0);
      chk("abort_cout", 32'(bus.Cout), 32'h0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.done === 1'b1) dones++;
         step();
      end
      chk("abort_no_done", 32'(dones), 32'd0);
      start_add(16'h0003, 16'h0004, 1'b1);
      wait_done(16'h0000, lat);
      chk("post_abort_latency", 32'(lat), 32'(NIB));
      chk("post_abort_sum", 32'(bus.sum), 32'h0008);
      chk("post_abort_cout", 32'(bus.Cout), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_nibble_serial_adder
